// File: rtl/if_fetch_stage_pkg.sv
// Shared types and defaults for the instruction-fetch stage and its IF/ID register.
package if_fetch_stage_pkg;

   localparam int          XLEN          = 32;
   localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;
   localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;   // addi x0,x0,0

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      FETCH = 2'd1,
      HOLD  = 2'd2
   } if_state_t;

   // IF/ID pipeline register contents, consumed by decode.
   typedef struct packed {
      logic            valid;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] pc4;
      logic [31:0]     instr;
   } ifid_t;

   // Instruction fetches are always word aligned.
   function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
      return {addr[XLEN-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/if_fetch_stage_if.sv
// Instruction-memory request/ready bus between the fetch stage (master) and imem (slave).
interface if_fetch_stage_if;
   import if_fetch_stage_pkg::*;

   logic            req;     // fetch request valid
   logic [XLEN-1:0] addr;    // word-aligned byte address
   logic [31:0]     rdata;   // instruction, valid when ready
   logic            ready;   // transfer = req & ready

   modport master (output req, output addr, input rdata, input ready);
   modport slave  (input req, input addr, output rdata, output ready);

endinterface

// File: rtl/if_fetch_stage_if_id_reg.sv
// IF/ID pipeline register: load a new record, clear to a bubble, or hold.
module if_fetch_stage_if_id_reg
   import if_fetch_stage_pkg::*;
#(
   parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
   input  logic  clk,
   input  logic  rst,          // synchronous, active low
   input  logic  load_i,
   input  logic  clear_i,      // wins over load_i
   input  ifid_t load_data_i,
   output ifid_t ifid_o
);

   localparam ifid_t RESET_VAL = '{valid: 1'b0, pc: '0, pc4: '0, instr: NOP_INSTR};

   ifid_t ifid_q;
   ifid_t ifid_d;

   // Next value: bubble on clear (pc fields kept, they are meaningless when invalid), new record on load.
   always_comb begin
      ifid_d = ifid_q;
      if (clear_i) begin
         ifid_d.valid = 1'b0;
         ifid_d.instr = NOP_INSTR;
      end else if (load_i) begin
         ifid_d = load_data_i;
      end
   end

   // Register with reset to the bubble encoding.
   always_ff @(posedge clk) begin
      if (!rst) ifid_q <= RESET_VAL;
      else      ifid_q <= ifid_d;
   end

   assign ifid_o = ifid_q;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC, fetch FSM, one-entry hold buffer and IF/ID register control.
module if_fetch_stage
   import if_fetch_stage_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEF,
   parameter logic [31:0]     NOP_INSTR = NOP_INSTR_DEF
) (
   input  logic                   clk,
   input  logic                   rst,            // synchronous, active low
   input  logic                   stall_i,
   input  logic                   redirect_i,
   input  logic [XLEN-1:0]        redirect_pc_i,
   if_fetch_stage_if.master       imem,
   output logic                   ifid_valid_o,
   output logic [XLEN-1:0]        ifid_pc_o,
   output logic [XLEN-1:0]        ifid_pc4_o,
   output logic [31:0]            ifid_instr_o
);

   if_state_t       state_q,      state_d;
   logic [XLEN-1:0] pc_q,         pc_d;
   logic [XLEN-1:0] hold_pc_q,    hold_pc_d;
   logic [31:0]     hold_instr_q, hold_instr_d;

   logic            transfer;
   logic [XLEN-1:0] pc_plus4;
   logic [XLEN-1:0] hold_pc_plus4;
   logic            ifid_load;
   logic            ifid_clear;
   ifid_t           ifid_load_data;
   ifid_t           ifid;

   // Requests only go out in FETCH; HOLD means the buffer is full so nothing is requested.
   assign imem.req  = (state_q == FETCH);
   assign imem.addr = pc_q;
   assign transfer  = imem.req & imem.ready;

   // PC+4 wraps modulo 2^XLEN.
   assign pc_plus4      = pc_q + XLEN'(4);
   assign hold_pc_plus4 = hold_pc_q + XLEN'(4);

   // Next-state, next-PC, hold buffer and IF/ID control; redirect overrides everything.
   always_comb begin
      state_d        = state_q;
      pc_d           = pc_q;
      hold_pc_d      = hold_pc_q;
      hold_instr_d   = hold_instr_q;
      ifid_load      = 1'b0;
      ifid_clear     = 1'b0;
      ifid_load_data = '{valid: 1'b1, pc: pc_q, pc4: pc_plus4, instr: imem.rdata};

      if (redirect_i) begin
         pc_d         = word_align(redirect_pc_i);
         hold_pc_d    = '0;
         hold_instr_d = NOP_INSTR;
         ifid_clear   = 1'b1;
         state_d      = FETCH;
      end else begin
         case (state_q)
            BOOT: begin
               state_d = FETCH;
            end
            FETCH: begin
               if (transfer && !stall_i) begin
                  ifid_load = 1'b1;
                  pc_d      = pc_plus4;
               end else if (transfer) begin
                  // Decode is stalled: park the instruction so it is not lost.
                  hold_pc_d    = pc_q;
                  hold_instr_d = imem.rdata;
                  pc_d         = pc_plus4;
                  state_d      = HOLD;
               end else if (!stall_i) begin
                  ifid_clear = 1'b1;
               end
            end
            HOLD: begin
               if (!stall_i) begin
                  ifid_load      = 1'b1;
                  ifid_load_data = '{valid: 1'b1, pc: hold_pc_q, pc4: hold_pc_plus4,
                                     instr: hold_instr_q};
                  state_d        = FETCH;
               end
            end
            default: begin
               state_d = BOOT;
            end
         endcase
      end
   end

   // State, PC and hold buffer registers.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= BOOT;
         pc_q         <= RESET_PC;
         hold_pc_q    <= '0;
         hold_instr_q <= NOP_INSTR;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         hold_pc_q    <= hold_pc_d;
         hold_instr_q <= hold_instr_d;
      end
   end

   if_fetch_stage_if_id_reg #(
      .NOP_INSTR (NOP_INSTR)
   ) u_if_id_reg (
      .clk         (clk),
      .rst         (rst),
      .load_i      (ifid_load),
      .clear_i     (ifid_clear),
      .load_data_i (ifid_load_data),
      .ifid_o      (ifid)
   );

   assign ifid_valid_o = ifid.valid;
   assign ifid_pc_o    = ifid.pc;
   assign ifid_pc4_o   = ifid.pc4;
   assign ifid_instr_o = ifid.instr;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed table-driven bench for if_fetch_stage; imem model returns the word index (mem[i]=i).
module tb_if_fetch_stage;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        valid;
   logic [31:0] ifid_pc;
   logic [31:0] ifid_pc4;
   logic [31:0] ifid_instr;

   if_fetch_stage_if imem ();

   if_fetch_stage dut (
      .clk           (clk),
      .rst           (rst),
      .stall_i       (stall),
      .redirect_i    (redirect),
      .redirect_pc_i (redirect_pc),
      .imem          (imem),
      .ifid_valid_o  (valid),
      .ifid_pc_o     (ifid_pc),
      .ifid_pc4_o    (ifid_pc4),
      .ifid_instr_o  (ifid_instr)
   );

   always #5 clk = ~clk;

   // Memory model: mem[i] = i, zero wait unless the bench lowers ready.
   assign imem.rdata = {2'b00, imem.addr[31:2]};

   typedef struct {
      logic        rst;
      logic        stall;
      logic        redir;
      logic [31:0] rpc;
      logic        ready;
      logic        e_req;
      logic [31:0] e_addr;    // compared only when e_req
      logic        e_valid;
      logic [31:0] e_pc;      // compared when e_valid or full
      logic [31:0] e_pc4;
      logic [31:0] e_instr;
      logic        full;
   } vec_t;

   vec_t vecs[30];
   int   n_vec = 0;
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic add(input logic r, input logic s, input logic rd, input logic [31:0] rp,
                      input logic rdy, input logic ereq, input logic [31:0] eaddr,
                      input logic ev, input logic [31:0] epc, input logic [31:0] epc4,
                      input logic [31:0] ein, input logic fl);
      vecs[n_vec] = '{rst: r, stall: s, redir: rd, rpc: rp, ready: rdy, e_req: ereq,
                      e_addr: eaddr, e_valid: ev, e_pc: epc, e_pc4: epc4, e_instr: ein, full: fl};
      n_vec++;
   endtask

   task automatic chk(input string name, input int row, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
      end
   endtask

   task automatic drive(input logic r, input logic s, input logic rd, input logic [31:0] rp,
                        input logic rdy);
      rst = r; stall = s; redirect = rd; redirect_pc = rp; imem.ready = rdy;
      @(posedge clk);
      #1;
   endtask

   task automatic show(input int row);
      $display("row %0d: req=%b addr=%h valid=%b pc=%h pc4=%h instr=%h",
               row, imem.req, imem.addr, valid, ifid_pc, ifid_pc4, ifid_instr);
   endtask

   initial begin
      rst = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0; imem.ready = 1'b1;

      //   rst stall redir rpc           rdy  req addr          v  pc            pc4           instr         full
      // Reset, boot, first fetch and stream
      add(0, 0, 0, 32'h0,          1,   0, 32'h0,        0, 32'h0,        32'h0,        NOP,          1);
      add(0, 0, 0, 32'h0,          1,   0, 32'h0,        0, 32'h0,        32'h0,        NOP,          1);
      add(1, 0, 0, 32'h0,          1,   1, 32'h0,        0, 32'h0,        32'h0,        NOP,          1);
      add(1, 0, 0, 32'h0,          1,   1, 32'h4,        1, 32'h0,        32'h4,        32'h0,        0);
      add(1, 0, 0, 32'h0,          1,   1, 32'h8,        1, 32'h4,        32'h8,        32'h1,        0);
      add(1, 0, 0, 32'h0,          1,   1, 32'hC,        1, 32'h8,        32'hC,        32'h2,        0);
      add(1, 0, 0, 32'h0,          1,   1, 32'h10,       1, 32'hC,        32'h10,       32'h3,        0);
      // Stall on transfer at 0x10 for three cycles
      add(1, 1, 0, 32'h0,          1,   0, 32'h0,        1, 32'hC,        32'h10,       32'h3,        0);
      add(1, 1, 0, 32'h0,          1,   0, 32'h0,        1, 32'hC,        32'h10,       32'h3,        0);
      add(1, 1, 0, 32'h0,          1,   0, 32'h0,        1, 32'hC,        32'h10,       32'h3,        0);
      add(1, 0, 0, 32'h0,          1,   1, 32'h14,       1, 32'h10,       32'h14,       32'h4,        0);
      add(1, 0, 0, 32'h0,          1,   1, 32'h18,       1, 32'h14,       32'h18,       32'h5,        0);
      // Redirect to 8 then two wait states
      add(1, 0, 1, 32'h8,          1,   1, 32'h8,        0, 32'h0,        32'h0,        NOP,          0);
      add(1, 0, 0, 32'h0,          0,   1, 32'h8,        0, 32'h0,        32'h0,        NOP,          0);
      add(1, 0, 0, 32'h0,          0,   1, 32'h8,        0, 32'h0,        32'h0,        NOP,          0);
      add(1, 0, 0, 32'h0,          1,   1, 32'hC,        1, 32'h8,        32'hC,        32'h2,        0);
      // Redirect with stall and ready, then redirect while in HOLD
      add(1, 1, 1, 32'h103,        1,   1, 32'h100,      0, 32'h0,        32'h0,        NOP,          0);
      add(1, 0, 0, 32'h0,          1,   1, 32'h104,      1, 32'h100,      32'h104,      32'h40,       0);
      add(1, 1, 0, 32'h0,          1,   0, 32'h0,        1, 32'h100,      32'h104,      32'h40,       0);
      add(1, 1, 1, 32'h200,        1,   1, 32'h200,      0, 32'h0,        32'h0,        NOP,          0);
      add(1, 1, 0, 32'h0,          1,   0, 32'h0,        0, 32'h0,        32'h0,        NOP,          0);
      add(1, 0, 0, 32'h0,          1,   1, 32'h204,      1, 32'h200,      32'h204,      32'h80,       0);
      // Wrap at top of address space
      add(1, 0, 1, 32'hFFFF_FFFC,  1,   1, 32'hFFFF_FFFC,0, 32'h0,        32'h0,        NOP,          0);
      add(1, 0, 0, 32'h0,          1,   1, 32'h0,        1, 32'hFFFF_FFFC,32'h0,        32'h3FFF_FFFF,0);
      add(1, 0, 0, 32'h0,          1,   1, 32'h4,        1, 32'h0,        32'h4,        32'h0,        0);
      // Reset while HOLD holds the instruction at 4
      add(1, 1, 0, 32'h0,          1,   0, 32'h0,        1, 32'h0,        32'h4,        32'h0,        0);
      add(0, 1, 0, 32'h0,          1,   0, 32'h0,        0, 32'h0,        32'h0,        NOP,          1);
      add(1, 0, 0, 32'h0,          1,   1, 32'h0,        0, 32'h0,        32'h0,        NOP,          1);
      add(1, 0, 0, 32'h0,          0,   1, 32'h0,        0, 32'h0,        32'h0,        NOP,          0);
      add(1, 0, 0, 32'h0,          1,   1, 32'h4,        1, 32'h0,        32'h4,        32'h0,        0);

      for (int i = 0; i < n_vec; i++) begin
         drive(vecs[i].rst, vecs[i].stall, vecs[i].redir, vecs[i].rpc, vecs[i].ready);
         show(i);
         chk("req",   i, {31'b0, imem.req}, {31'b0, vecs[i].e_req});
         chk("valid", i, {31'b0, valid},    {31'b0, vecs[i].e_valid});
         chk("instr", i, ifid_instr,        vecs[i].e_instr);
         if (vecs[i].e_req)
            chk("addr", i, imem.addr, vecs[i].e_addr);
         if (vecs[i].e_valid || vecs[i].full) begin
            chk("pc",  i, ifid_pc,  vecs[i].e_pc);
            chk("pc4", i, ifid_pc4, vecs[i].e_pc4);
         end
      end

      // Redirect taken straight out of BOOT, unaligned target
      drive(0, 0, 0, 32'h0, 1);
      show(100);
      chk("boot_rst_valid", 100, {31'b0, valid}, 32'h0);
      drive(1, 0, 1, 32'h42, 1);
      show(101);
      chk("boot_redir_req",   101, {31'b0, imem.req}, 32'h1);
      chk("boot_redir_addr",  101, imem.addr, 32'h40);
      chk("boot_redir_valid", 101, {31'b0, valid}, 32'h0);
      drive(1, 0, 0, 32'h0, 1);
      show(102);
      chk("boot_redir_pc",    102, ifid_pc, 32'h40);
      chk("boot_redir_pc4",   102, ifid_pc4, 32'h44);
      chk("boot_redir_instr", 102, ifid_instr, 32'h10);

      // Wait states while stalled leave IF/ID untouched, then delivery resumes in order
      drive(1, 1, 0, 32'h0, 0);
      show(103);
      chk("stall_wait_valid", 103, {31'b0, valid}, 32'h1);
      chk("stall_wait_pc",    103, ifid_pc, 32'h40);
      chk("stall_wait_addr",  103, imem.addr, 32'h44);
      drive(1, 0, 0, 32'h0, 1);
      show(104);
      chk("resume_pc",    104, ifid_pc, 32'h44);
      chk("resume_instr", 104, ifid_instr, 32'h11);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
